keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Scans a 4x4 active-low matrix keypad and debounces key presses.
- Converts each accepted press into a 4-bit hex code.
- Shifts accepted codes into an 8-bit value that feeds the two-digit seven-segment display driver's I_show_num.
- Input-side counterpart of the display path: rows are strobed one-hot-low, the same way the display strobes its digit selects.

Parameters:
- C_SCAN_NUM, 1000, clock cycles each row is driven before columns are sampled (settle time); legal range >= 4.
- C_DEBOUNCE_NUM, 200000, consecutive stable cycles required to accept a press or a release; legal range >= 2.
- C_REPEAT_NUM, 5000000, cycles between repeated codes while a key is held (used only with the optional feature).

Ports:
- I_clk  input  1  system clock.
- I_rst  input  1  reset, asynchronous, active-low.
- I_col  input  4  keypad column lines, active-low, asynchronous to I_clk.
- O_row  output  4  keypad row drive, one-hot-low.
- O_key  output  4  code of the most recently accepted key.
- O_key_valid  output  1  one-cycle pulse when a code is accepted.
- O_num  output  8  shift register of the last two accepted codes; connects to I_show_num.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: O_row=4'b1110, O_key=0, O_key_valid=0, O_num=0, state SCAN, all counters 0.
- I_col passes through a 2-flop synchronizer before any use. This adds 2 cycles of latency; "col" below means the synchronized value.
- Key code = {row_index[1:0], col_index[1:0]}. Example: row 2, col 1 gives 4'h9.
- Counters are 32 bits and compare with >= against (parameter - 1).
- State SCAN:
  - The counter increments while the current row is driven.
  - When the counter reaches C_SCAN_NUM-1, col is sampled.
  - If any col bit is 0: latch the current row and the lowest-index low column, clear the counter, go to DEBOUNCE.
  - Otherwise rotate O_row left (1110 -> 1101 -> 1011 -> 0111 -> 1110) and clear the counter.
- State DEBOUNCE:
  - O_row is held.
  - If the latched col bit is 0, the counter increments. If it is 1, clear the counter and return to SCAN on the same row.
  - When the counter reaches C_DEBOUNCE_NUM-1 with the bit still 0: go to PRESSED and, on the transition cycle's edge, set O_key=code, O_num={O_num[3:0],code}, O_key_valid=1.
  - O_key_valid drops the next cycle.
- State PRESSED:
  - O_row is held. Presses on other keys are ignored.
  - When the latched col bit reads 1: clear the counter, go to RELEASE.
- State RELEASE:
  - The counter increments while the latched col bit is 1.
  - If the bit returns to 0: go back to PRESSED with no new code.
  - When the counter reaches C_DEBOUNCE_NUM-1: rotate O_row, clear the counter, go to SCAN.
- Boundary conditions:
  - Multiple columns low in one row: the lowest index wins.
  - Multiple rows pressed: only the row being driven at the sample point is seen.
  - O_num wraps by shifting, so the oldest nibble is dropped.
  - Reset in any state returns everything to the reset values immediately, with no pulse emitted.
  - Exactly one O_key_valid pulse per accepted press.

Optional Feature:
- Macro KEYPAD_AUTOREPEAT_EN.
- When defined: in PRESSED, a repeat counter runs from entry. Each time it reaches C_REPEAT_NUM-1, O_key_valid pulses with the same code, O_num shifts, and the repeat counter clears. The counter is cleared on leaving PRESSED.
- When undefined: no repeat logic or counter is synthesized, and C_REPEAT_NUM is unused.

Decomposition:
- Shared package keypad_pkg contains:
  - state encoding typedef (SCAN, DEBOUNCE, PRESSED, RELEASE)
  - row reset constant 4'b1110
  - key-code width constant 4
  - counter width constant 32
- One sub-module: keypad_col_sync, a 4-bit 2-flop synchronizer with asynchronous active-low reset to 4'b1111.

Test Plan:
Use C_SCAN_NUM=4, C_DEBOUNCE_NUM=8, C_REPEAT_NUM=32. The keypad model pulls I_col[c] low when O_row[r]=0 for each pressed (r,c).
- No key pressed -> O_row cycles 1110, 1101, 1011, 0111, 1110 every 4 cycles; O_key_valid is never asserted.
- Press (2,1) held for 40 cycles, then release -> exactly one O_key_valid pulse, O_key=4'h9, O_num=8'h09; scanning resumes after 8 high cycles.
- Press (0,3), then (3,2), each held and released cleanly -> O_num goes 8'h03, then 8'h3E; two pulses total.
- Press (1,0) with a 3-cycle glitch, then 10 cycles released -> no pulse; state returns to SCAN on row 1.
- (1,0) and (1,2) pressed together -> O_key=4'h4; a release bounce of 3 cycles inside RELEASE produces no second pulse.
- Reset asserted mid-DEBOUNCE -> O_row=1110, O_num=0, O_key_valid=0 immediately. With KEYPAD_AUTOREPEAT_EN, holding (0,0) for 100 cycles gives pulses at acceptance and every 32 cycles thereafter.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared state encoding, widths and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;
  localparam int unsigned NUM_W = 2 * KEY_W;

  localparam logic [ROW_W-1:0] ROW_RESET = 4'b1110;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // Index of the lowest-numbered low bit of an active-low 4-bit vector.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad column lines.
module keypad_col_sync
  import keypad_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [COL_W-1:0] meta_q;
  logic [COL_W-1:0] sync_q;

  // Idle columns read high, so reset to the released value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= col_i;
      sync_q <= meta_q;
    end
  end

  assign col_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and a two-digit code shifter.
// Optional hold-to-repeat enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned C_SCAN_NUM     = 1000,
  parameter int unsigned C_DEBOUNCE_NUM = 200000,
  parameter int unsigned C_REPEAT_NUM   = 5000000
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic [3:0] I_col,
  output logic [3:0] O_row,
  output logic [3:0] O_key,
  output logic       O_key_valid,
  output logic [7:0] O_num
);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(C_SCAN_NUM - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(C_DEBOUNCE_NUM - 1);

  logic [COL_W-1:0] col_sync;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       krow_q, krow_d;
  logic [1:0]       kcol_q, kcol_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             valid_q, valid_d;

  logic             key_up;
  logic [KEY_W-1:0] key_code;
  logic [ROW_W-1:0] row_rot;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(C_REPEAT_NUM - 1);
  logic [CNT_W-1:0] rep_q, rep_d;
`endif

  keypad_col_sync u_col_sync (
    .clk_i  (I_clk),
    .rst_ni (I_rst),
    .col_i  (I_col),
    .col_o  (col_sync)
  );

  assign key_up   = col_sync[kcol_q];
  assign key_code = {krow_q, kcol_q};
  assign row_rot  = {row_q[ROW_W-2:0], row_q[ROW_W-1]};

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state_q <= ST_SCAN;
      row_q   <= ROW_RESET;
      cnt_q   <= '0;
      krow_q  <= '0;
      kcol_q  <= '0;
      key_q   <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      krow_q  <= krow_d;
      kcol_q  <= kcol_d;
      key_q   <= key_d;
      num_q   <= num_d;
      valid_q <= valid_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

  // Next-state: one counter is shared by row settle, press debounce and release debounce.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    krow_d  = krow_q;
    kcol_d  = kcol_q;
    key_d   = key_q;
    num_d   = num_q;
    valid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = '0;
`endif

    case (state_q)
      ST_SCAN: begin
        if (cnt_q >= SCAN_LAST) begin
          cnt_d = '0;
          if (col_sync != '1) begin
            krow_d  = low_index(row_q);
            kcol_d  = low_index(col_sync);
            state_d = ST_DEBOUNCE;
          end else begin
            row_d = row_rot;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (key_up) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
        end else if (cnt_q >= DEB_LAST) begin
          cnt_d   = '0;
          state_d = ST_PRESSED;
          key_d   = key_code;
          num_d   = {num_q[KEY_W-1:0], key_code};
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_PRESSED: begin
        if (key_up) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rep_q >= REP_LAST) begin
          key_d   = key_code;
          num_d   = {num_q[KEY_W-1:0], key_code};
          valid_d = 1'b1;
        end else begin
          rep_d = rep_q + CNT_W'(1);
        end
`endif
      end

      ST_RELEASE: begin
        if (!key_up) begin
          cnt_d   = '0;
          state_d = ST_PRESSED;
        end else if (cnt_q >= DEB_LAST) begin
          cnt_d   = '0;
          row_d   = row_rot;
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  assign O_row       = row_q;
  assign O_key       = key_q;
  assign O_key_valid = valid_q;
  assign O_num       = num_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad matrix model drives the columns, and a
// cycle model of the scanning rules is compared against the DUT every cycle.
module tb_keypad_scan;

  localparam int unsigned SCAN_N = 4;
  localparam int unsigned DEB_N  = 8;
  localparam int unsigned REP_N  = 32;

  localparam int P_IDLE = 0;
  localparam int P_QUAL = 1;
  localparam int P_HELD = 2;
  localparam int P_LIFT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic [7:0] num;
  logic [15:0] press;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  keypad_scan #(
    .C_SCAN_NUM     (SCAN_N),
    .C_DEBOUNCE_NUM (DEB_N),
    .C_REPEAT_NUM   (REP_N)
  ) dut (
    .I_clk       (clk),
    .I_rst       (rst_n),
    .I_col       (col),
    .O_row       (row),
    .O_key       (key),
    .O_key_valid (key_valid),
    .O_num       (num)
  );

  // Keypad matrix: a pressed key shorts its column to a row that is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  function automatic logic [3:0] row_of(input int i);
    case (i)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [3:0] pad_cols(input int r, input logic [15:0] p);
    logic [3:0] c;
    c = 4'hF;
    for (int k = 0; k < 4; k++) if (p[r*4+k]) c[k] = 1'b0;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase, dwell/run lengths and the two-cycle column delay.
  int         m_phase, m_row_i, m_dwell, m_run, m_rep, m_kr, m_kc;
  logic [3:0] m_s1, m_s2, m_seen, m_key;
  logic [7:0] m_num;
  logic       m_valid;

  task automatic m_emit();
    m_key   = 4'(m_kr * 4 + m_kc);
    m_num   = {m_num[3:0], m_key};
    m_valid = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_row_i = 0; m_dwell = 0; m_run = 0; m_rep = 0;
      m_kr = 0; m_kc = 0; m_s1 = 4'hF; m_s2 = 4'hF;
      m_key = 4'h0; m_num = 8'h00; m_valid = 1'b0;
    end else begin
      m_seen  = m_s2;
      m_s2    = m_s1;
      m_s1    = pad_cols(m_row_i, press);
      m_valid = 1'b0;
      case (m_phase)
        P_IDLE: begin
          m_dwell++;
          if (m_dwell == SCAN_N) begin
            m_dwell = 0;
            if (m_seen != 4'hF) begin
              m_kr = m_row_i;
              for (int k = 3; k >= 0; k--) if (!m_seen[k]) m_kc = k;
              m_run   = 0;
              m_phase = P_QUAL;
            end else begin
              m_row_i = (m_row_i + 1) % 4;
            end
          end
        end
        P_QUAL: begin
          if (!m_seen[m_kc]) begin
            m_run++;
            if (m_run == DEB_N) begin
              m_emit();
              m_rep   = 0;
              m_phase = P_HELD;
            end
          end else begin
            m_dwell = 0;
            m_phase = P_IDLE;
          end
        end
        P_HELD: begin
          if (m_seen[m_kc]) begin
            m_run   = 0;
            m_phase = P_LIFT;
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            m_rep++;
            if (m_rep == REP_N) begin
              m_emit();
              m_rep = 0;
            end
`endif
          end
        end
        default: begin
          if (m_seen[m_kc]) begin
            m_run++;
            if (m_run == DEB_N) begin
              m_dwell = 0;
              m_row_i = (m_row_i + 1) % 4;
              m_phase = P_IDLE;
            end
          end else begin
            m_rep   = 0;
            m_phase = P_HELD;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("row",   32'(row),       32'(row_of(m_row_i)));
    chk("key",   32'(key),       32'(m_key));
    chk("valid", 32'(key_valid), 32'(m_valid));
    chk("num",   32'(num),       32'(m_num));
  end

  always @(negedge clk) if (key_valid === 1'b1) pulses++;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    press = '0;
    cycles(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_pulse(input string name, input int budget);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < budget) begin
      cycles(1);
      n++;
    end
    chk(name, 32'(key_valid === 1'b1), 32'd1);
  endtask

  task automatic wait_row(input string name, input logic [3:0] target, input logic equal);
    int n;
    n = 0;
    while (((row === target) != equal) && n < 64) begin
      cycles(1);
      n++;
    end
    chk(name, 32'((row === target) == equal), 32'd1);
  endtask

  initial begin
    int p0;
    rst_n = 1'b0;
    press = '0;
    cycles(3);
    chk("rst_row",   32'(row),       32'h0E);
    chk("rst_key",   32'(key),       32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_num",   32'(num),       32'h00);
    rst_n = 1'b1;

    // Idle scan: each row held for four cycles, no pulses.
    p0 = pulses;
    for (int j = 1; j <= 16; j++) begin
      cycles(1);
      chk("idle_row", 32'(row), 32'(row_of((j / 4) % 4)));
    end
    chk("idle_pulses", 32'(pulses - p0), 32'd0);

    // Single clean press of (2,1).
    p0 = pulses;
    press[2*4+1] = 1'b1;
    cycles(40);
    press = '0;
    cycles(30);
    chk("k9_pulses", 32'(pulses - p0), 32'd1);
    chk("k9_key",    32'(key),         32'h9);
    chk("k9_num",    32'(num),         32'h09);

    // Two presses shift into the display value.
    do_reset();
    p0 = pulses;
    press[0*4+3] = 1'b1;
    wait_pulse("k3_seen", 60);
    chk("k3_key", 32'(key), 32'h3);
    chk("k3_num", 32'(num), 32'h03);
    cycles(2);
    press = '0;
    cycles(30);
    press[3*4+2] = 1'b1;
    wait_pulse("ke_seen", 60);
    chk("ke_key", 32'(key), 32'hE);
    chk("ke_num", 32'(num), 32'h3E);
    cycles(2);
    press = '0;
    cycles(30);
    chk("two_pulses", 32'(pulses - p0), 32'd2);

    // Short glitch on (1,0) while row 1 is sampled: rejected, row 1 rescanned.
    wait_row("glitch_leave", 4'b1101, 1'b0);
    wait_row("glitch_enter", 4'b1101, 1'b1);
    p0 = pulses;
    press[1*4+0] = 1'b1;
    cycles(3);
    press = '0;
    cycles(4);
    chk("glitch_row", 32'(row), 32'h0D);
    cycles(10);
    chk("glitch_pulses", 32'(pulses - p0), 32'd0);

    // Two keys in one row, then a release bounce.
    p0 = pulses;
    press[1*4+0] = 1'b1;
    press[1*4+2] = 1'b1;
    wait_pulse("k4_seen", 60);
    chk("k4_key", 32'(key), 32'h4);
    cycles(1);
    press = '0;
    cycles(5);
    press[1*4+0] = 1'b1;
    press[1*4+2] = 1'b1;
    cycles(3);
    press = '0;
    cycles(30);
    chk("bounce_pulses", 32'(pulses - p0), 32'd1);
    chk("k4_num", 32'(num), 32'hE4);

    // Reset while a press on row 3 is being debounced.
    wait_row("r3_leave", 4'b0111, 1'b0);
    press[3*4+3] = 1'b1;
    wait_row("r3_enter", 4'b0111, 1'b1);
    cycles(6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_row",   32'(row),       32'h0E);
    chk("mid_rst_num",   32'(num),       32'h00);
    chk("mid_rst_key",   32'(key),       32'h0);
    chk("mid_rst_valid", 32'(key_valid), 32'h0);
    press = '0;
    cycles(2);
    rst_n = 1'b1;
    cycles(10);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Hold (0,0) from reset: accepted, then repeated every REP_N cycles.
    rst_n = 1'b0;
    press = '0;
    cycles(2);
    press[0] = 1'b1;
    p0 = pulses;
    rst_n = 1'b1;
    cycles(100);
    chk("repeat_pulses", 32'(pulses - p0), 32'd3);
    press = '0;
    cycles(30);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
